pipe_cla_adder: RTL and testbench

//  Pipelined, parametrised carry-lookahead adder for the square-root datapath.

---
 rtl/pipe_cla_pkg.sv | 21 ++
 rtl/cla_block.sv | 56 +++++
 rtl/pipe_cla_adder.sv | 140 ++++++++++++++
 tb/tb_pipe_cla_adder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder.
// Latency: n/a (package of constants and elaboration-time functions).
// Backpressure: n/a.
//
// Contents:
//   DEFAULT_BLOCK  default CLA slice width
//   nstages()      number of pipeline stages, ceil(width/block)
//   last_slice_w() width of the most significant slice (may be narrower than block)
package pipe_cla_pkg;

   localparam int DEFAULT_BLOCK = 4;

   function automatic int nstages(input int width, input int block);
      return (width + block - 1) / block;
   endfunction

   function automatic int last_slice_w(input int width, input int block);
      return width - (nstages(width, block) - 1) * block;
   endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational W-bit carry-lookahead slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing pipeline owns all flow control.
//
// Ports:
//   A_i, B_i [W-1:0]  slice operands
//   Ci_i              carry into bit 0 of the slice
//   S_o      [W-1:0]  slice sum
//   Co_o              carry out of the slice MSB
module cla_block #(
   parameter int W = 4
) (
   input  logic [W-1:0] A_i,
   input  logic [W-1:0] B_i,
   input  logic         Ci_i,
   output logic [W-1:0] S_o,
   output logic         Co_o
);

   logic [W-1:0] gen;
   logic [W-1:0] prop;
   logic [W:0]   carry;
   logic         chain;
   logic         term;

   assign gen  = A_i & B_i;
   assign prop = A_i ^ B_i;

   // Each carry is built directly from the generate/propagate terms of all
   // lower bits rather than from the carry one bit below:
   //   c[i+1] = Ci & p[0..i]  |  OR_j ( g[j] & p[j+1..i] )
   always_comb begin
      carry    = '0;
      chain    = 1'b0;
      term     = 1'b0;
      carry[0] = Ci_i;
      for (int i = 0; i < W; i++) begin
         chain = Ci_i;
         for (int j = 0; j <= i; j++) begin
            chain = chain & prop[j];
         end
         carry[i+1] = chain;
         for (int j = 0; j <= i; j++) begin
            term = gen[j];
            for (int k = j + 1; k <= i; k++) begin
               term = term & prop[k];
            end
            carry[i+1] = carry[i+1] | term;
         end
      end
   end

   assign S_o  = prop ^ carry[W-1:0];
   assign Co_o = carry[W];

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined WIDTH-bit adder built from BLOCK-bit CLA slices, one slice per stage.
// Latency: NSTAGES = ceil(WIDTH/BLOCK) cycles from acceptance to valid_o; one add per cycle.
// Backpressure: whole pipe advances only when !valid_o || ready_i; ready_o mirrors that enable.
//
// Ports:
//   clk_i, rst_n_i            clock (rising edge), asynchronous active-low reset
//   valid_i/ready_o           operand handshake; A_i, B_i, Ci_i sampled on valid_i && ready_o
//   valid_o/ready_i           result handshake; S_o, Co_o held stable while stalled
//   sub_i                     only with PIPE_CLA_SUB_EN defined: 1 -> A_i + ~B_i + 1, Ci_i ignored
//
// Build option: define PIPE_CLA_SUB_EN to add the sub_i port and subtract mode.
module pipe_cla_adder
   import pipe_cla_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int BLOCK = DEFAULT_BLOCK
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   input  logic             Ci_i,
`ifdef PIPE_CLA_SUB_EN
   input  logic             sub_i,
`endif
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] S_o,
   output logic             Co_o
);

   localparam int NS = nstages(WIDTH, BLOCK);
   localparam int LW = last_slice_w(WIDTH, BLOCK);

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;
   logic [NS-1:0]    vld_q;

   // Operand conditioning in front of stage 0. Subtraction is two's
   // complement: invert B and force the carry-in to one.
`ifdef PIPE_CLA_SUB_EN
   assign b_eff = sub_i ? ~B_i : B_i;
   assign c_eff = sub_i ? 1'b1 : Ci_i;
`else
   assign b_eff = B_i;
   assign c_eff = Ci_i;
`endif

   // Single global enable: every stage moves together or nothing moves, so
   // a bubble inside the pipe is never squeezed out while the output stalls.
   assign valid_o = vld_q[NS-1];
   assign adv     = !valid_o || ready_i;
   assign ready_o = adv;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         vld_q <= '0;
      end else if (adv) begin
         vld_q[0] <= valid_i;
         for (int k = 1; k < NS; k++) begin
            vld_q[k] <= vld_q[k-1];
         end
      end
   end

   // Stage k adds slice k. Its operand bits arrive through the skew
   // registers of stage k-1 (already shifted down so the slice sits at bit 0),
   // and the partial sum grows by one slice per stage in the de-skew register.
   for (genvar k = 0; k < NS; k++) begin : g_st
      localparam bit LAST = (k == NS - 1);
      localparam int SW   = LAST ? LW : BLOCK;   // slice width at this stage
      localparam int IW   = WIDTH - k * BLOCK;   // operand bits not yet summed
      localparam int LO   = k * BLOCK;           // sum bits finished upstream

      logic [IW-1:0]    a_in;
      logic [IW-1:0]    b_in;
      logic             c_in;
      logic [SW-1:0]    s_sl;
      logic             c_sl;
      logic [LO+SW-1:0] s_d;
      logic [LO+SW-1:0] s_q;
      logic             c_q;

      if (k == 0) begin : g_src
         assign a_in = A_i;
         assign b_in = b_eff;
         assign c_in = c_eff;
         assign s_d  = s_sl;
      end else begin : g_src
         assign a_in = g_st[k-1].g_skew.a_q;
         assign b_in = g_st[k-1].g_skew.b_q;
         assign c_in = g_st[k-1].c_q;
         assign s_d  = {s_sl, g_st[k-1].s_q};
      end

      cla_block #(
         .W (SW)
      ) u_cla (
         .A_i  (a_in[SW-1:0]),
         .B_i  (b_in[SW-1:0]),
         .Ci_i (c_in),
         .S_o  (s_sl),
         .Co_o (c_sl)
      );

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            s_q <= '0;
            c_q <= 1'b0;
         end else if (adv) begin
            s_q <= s_d;
            c_q <= c_sl;
         end
      end

      // Upper operand bits still waiting for their slice; the final stage
      // consumes everything, so it has no skew register.
      if (!LAST) begin : g_skew
         logic [IW-SW-1:0] a_q;
         logic [IW-SW-1:0] b_q;

         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_in[IW-1:SW];
               b_q <= b_in[IW-1:SW];
            end
         end
      end
   end

   assign S_o  = g_st[NS-1].s_q;
   assign Co_o = g_st[NS-1].c_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder (16/4 main instance, 9/4 side instance).
// Latency: checks NSTAGES-cycle latency of both instances.
// Backpressure: exercises stalls, hold stability, random ready/valid traffic.
module tb_pipe_cla_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        valid_in, ready_out, valid_out, ready_in, ci_in, co_out;
   logic [15:0] a_in, b_in, s_out;
   logic        v9_in, r9_out, v9_out, r9_in, c9_in, co9_out;
   logic [8:0]  a9_in, b9_in, s9_out;
`ifdef PIPE_CLA_SUB_EN
   logic        sub_in;
   logic        sub9_in;
`endif

   int checks   = 0;
   int failures = 0;

   pipe_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .valid_i (valid_in),
      .ready_o (ready_out),
      .A_i     (a_in),
      .B_i     (b_in),
      .Ci_i    (ci_in),
`ifdef PIPE_CLA_SUB_EN
      .sub_i   (sub_in),
`endif
      .valid_o (valid_out),
      .ready_i (ready_in),
      .S_o     (s_out),
      .Co_o    (co_out)
   );

   pipe_cla_adder #(.WIDTH(9), .BLOCK(4)) dut9 (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .valid_i (v9_in),
      .ready_o (r9_out),
      .A_i     (a9_in),
      .B_i     (b9_in),
      .Ci_i    (c9_in),
`ifdef PIPE_CLA_SUB_EN
      .sub_i   (sub9_in),
`endif
      .valid_o (v9_out),
      .ready_i (r9_in),
      .S_o     (s9_out),
      .Co_o    (co9_out)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic [15:0] s;
      logic        co;
   } vec_t;

   vec_t        tbl[9];
   logic [16:0] q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain unsigned addition, 17-bit result {carry, sum}.
   function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                           input logic ci);
      return {1'b0, a} + {1'b0, b} + {16'd0, ci};
   endfunction

   // Present one op (called #1 after a posedge), count cycles to valid_o.
   task automatic single_op(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic [15:0] es, input logic eco);
      int n;
      n = 0;
      valid_in = 1'b1; a_in = a; b_in = b; ci_in = ci; ready_in = 1'b1;
      while (n < 20) begin
         @(posedge clk); n++;
         #1 valid_in = 1'b0;
         @(negedge clk);
         if (valid_out) break;
      end
      check({name, " latency"}, n, 4);
      check({name, " sum"}, s_out, es);
      check({name, " carry"}, co_out, eco);
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          n, got, vseen;
      logic [16:0] e;
      logic        hold_pend;
      logic [15:0] held_s;
      logic        held_co;

      tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      tbl[1] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0};
      tbl[2] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
      tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      tbl[6] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
      tbl[7] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
      tbl[8] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

      rst_n = 1'b0;
      valid_in = 1'b0; a_in = '0; b_in = '0; ci_in = 1'b0; ready_in = 1'b0;
      v9_in = 1'b0; a9_in = '0; b9_in = '0; c9_in = 1'b0; r9_in = 1'b0;
`ifdef PIPE_CLA_SUB_EN
      sub_in = 1'b0; sub9_in = 1'b0;
`endif

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset valid_o", valid_out, 0);
      check("reset S_o", s_out, 0);
      check("reset Co_o", co_out, 0);
      check("reset ready_o", ready_out, 1);
      check("reset valid_o w9", v9_out, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table of isolated ops
      for (int i = 0; i < 9; i++) begin
         single_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].co);
      end

      // Three back-to-back ops, results on consecutive cycles
      ready_in = 1'b1;
      valid_in = 1'b1; a_in = 16'h0001; b_in = 16'h0002; ci_in = 1'b0;
      @(posedge clk); #1 a_in = 16'h00FF; b_in = 16'h0001;
      @(posedge clk); #1 a_in = 16'h8000; b_in = 16'h8000;
      @(posedge clk); #1 valid_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("b2b r0 valid", valid_out, 1);
      check("b2b r0", {co_out, s_out}, 17'h00003);
      @(negedge clk);
      check("b2b r1 valid", valid_out, 1);
      check("b2b r1", {co_out, s_out}, 17'h00100);
      @(negedge clk);
      check("b2b r2 valid", valid_out, 1);
      check("b2b r2", {co_out, s_out}, 17'h10000);
      @(negedge clk);
      check("b2b drained", valid_out, 0);
      @(posedge clk); #1;

      // Fill with output stalled, hold 5 cycles, then drain
      ready_in = 1'b0;
      q.delete();
      for (int i = 0; i < 4; i++) begin
         valid_in = 1'b1;
         a_in = 16'h1111 * 16'(i + 1) + 16'hF000;
         b_in = 16'h0F0F + 16'(i * 3);
         ci_in = i[0];
         q.push_back(ref_add(a_in, b_in, ci_in));
         @(posedge clk); #1;
      end
      valid_in = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall ready_o", ready_out, 0);
         check("stall valid_o", valid_out, 1);
         check("stall S_o", {co_out, s_out}, q[0]);
         @(posedge clk); #1;
      end
      ready_in = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         @(negedge clk);
         if (valid_out) begin
            e = q.pop_front();
            check("stall drain result", {co_out, s_out}, e);
            got++;
         end
         @(posedge clk); #1;
      end
      check("stall drain count", got, 4);
      @(negedge clk);
      check("stall no duplicate", valid_out, 0);
      @(posedge clk); #1;

      // Asynchronous reset with ops in flight
      ready_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1; a_in = 16'h0100 + 16'(i); b_in = 16'h0011; ci_in = 1'b0;
         @(posedge clk); #1;
      end
      valid_in = 1'b0;
      @(posedge clk); #1;
      check("pre-reset valid_o", valid_out, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset valid_o", valid_out, 0);
      check("async reset S_o", s_out, 0);
      @(posedge clk); #3 rst_n = 1'b1;
      vseen = 0;
      repeat (8) begin
         @(negedge clk);
         if (valid_out) vseen++;
      end
      check("post-reset no stale output", vseen, 0);
      @(posedge clk); #1;
      single_op("post-reset op", 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0);

      // WIDTH=9, BLOCK=4: three stages, narrow last slice
      v9_in = 1'b1; a9_in = 9'h1FF; b9_in = 9'h1FF; c9_in = 1'b1; r9_in = 1'b1;
      n = 0;
      while (n < 20) begin
         @(posedge clk); n++;
         #1 v9_in = 1'b0;
         @(negedge clk);
         if (v9_out) break;
      end
      check("w9 latency", n, 3);
      check("w9 sum", s9_out, 9'h1FF);
      check("w9 carry", co9_out, 1);
      @(posedge clk); #1;

`ifdef PIPE_CLA_SUB_EN
      sub_in = 1'b1;
      single_op("sub 5-7", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
      single_op("sub 7-5", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
      sub_in = 1'b0;
`endif

      // Random traffic against the queue model
      q.delete();
      hold_pend = 1'b0;
      held_s = '0;
      held_co = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         valid_in = ($urandom_range(0, 3) != 0);
         a_in     = 16'($urandom);
         b_in     = 16'($urandom);
         ci_in    = 1'($urandom);
         ready_in = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (hold_pend) begin
            check("rand hold valid", valid_out, 1);
            check("rand hold data", {co_out, s_out}, {held_co, held_s});
            hold_pend = 1'b0;
         end
         if (valid_out && ready_in) begin
            if (q.size() == 0) begin
               check("rand spurious output", valid_out, 0);
            end else begin
               e = q.pop_front();
               check("rand result", {co_out, s_out}, e);
            end
         end else if (valid_out) begin
            hold_pend = 1'b1;
            held_s    = s_out;
            held_co   = co_out;
         end
         if (valid_in && ready_out) q.push_back(ref_add(a_in, b_in, ci_in));
         @(posedge clk); #1;
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      for (int c = 0; c < 20 && q.size() > 0; c++) begin
         @(negedge clk);
         if (valid_out) begin
            e = q.pop_front();
            check("rand drain result", {co_out, s_out}, e);
         end
         @(posedge clk); #1;
      end
      check("rand all results seen", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
